// File: rtl/id_stage_v2.sv
// id_stage_v2: decode stage between fetch and EXE.
// Decodes an LA32R integer subset and reads the regfile combinationally.
// The decoded control word is registered behind a valid/ready handshake.
// An optional skid entry keeps in_ready registered.
// A load-use interlock holds back instructions that depend on a load in EXE.
module id_stage_v2 #(
    parameter int ALU_OP_W = 14,
    parameter int BR_OP_W  = 8,
    parameter bit SKID_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_inst,
    output logic [4:0]          reg_index1,
    output logic [4:0]          reg_index2,
    input  logic [31:0]         reg_data1,
    input  logic [31:0]         reg_data2,
    input  logic                ex_ld_valid,
    input  logic [4:0]          ex_ld_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_inst,
    output logic [31:0]         out_src1,
    output logic [31:0]         out_src2,
    output logic [31:0]         out_imm,
    output logic [4:0]          out_rd,
    output logic                out_we,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [BR_OP_W-1:0]  out_br_op,
    output logic [1:0]          out_mem_op,
    output logic                out_sel_src1,
    output logic                out_sel_src2,
    output logic                out_inst_valid
);

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 6;
    localparam int ALU_LUI  = 7;

    localparam int BR_JIRL = 0;
    localparam int BR_B    = 1;
    localparam int BR_BL   = 2;
    localparam int BR_BEQ  = 3;
    localparam int BR_BNE  = 4;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         inst;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [31:0]         imm;
        logic [4:0]          rd;
        logic                we;
        logic [ALU_OP_W-1:0] alu_op;
        logic [BR_OP_W-1:0]  br_op;
        logic [1:0]          mem_op;
        logic                sel_src1;
        logic                sel_src2;
        logic                inst_valid;
    } entry_t;

    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [31:0] imm_si12, imm_ui12, imm_si20, imm_offs16, imm_offs26;

    assign op17 = in_inst[31:15];
    assign op10 = in_inst[31:22];
    assign op7  = in_inst[31:25];
    assign op6  = in_inst[31:26];

    assign imm_si12   = {{20{in_inst[21]}}, in_inst[21:10]};
    assign imm_ui12   = {20'h0, in_inst[21:10]};
    assign imm_si20   = {in_inst[24:5], 12'h0};
    assign imm_offs16 = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
    assign imm_offs26 = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};

    entry_t dec;
    logic   use_rj;
    logic   use_src2;
    logic   src2_is_rd;

    // Instruction decode; the opcode tables are disjoint, so at most one case arm hits.
    always_comb begin
        dec        = '0;
        use_rj     = 1'b0;
        use_src2   = 1'b0;
        src2_is_rd = 1'b0;
        dec.pc     = in_pc;
        dec.inst   = in_inst;
        dec.src1   = reg_data1;
        dec.src2   = reg_data2;
        dec.rd     = in_inst[4:0];

        case (op17)
            17'h00020: dec.alu_op[ALU_ADD]  = 1'b1;
            17'h00022: dec.alu_op[ALU_SUB]  = 1'b1;
            17'h00024: dec.alu_op[ALU_SLT]  = 1'b1;
            17'h00025: dec.alu_op[ALU_SLTU] = 1'b1;
            17'h00029: dec.alu_op[ALU_AND]  = 1'b1;
            17'h0002a: dec.alu_op[ALU_OR]   = 1'b1;
            17'h0002b: dec.alu_op[ALU_XOR]  = 1'b1;
            default: ;
        endcase
        if (dec.alu_op != '0) begin
            dec.inst_valid = 1'b1;
            dec.we         = 1'b1;
            use_rj         = 1'b1;
            use_src2       = 1'b1;
        end

        case (op10)
            10'h008: begin
                dec.alu_op[ALU_SLT] = 1'b1;
                dec.imm             = imm_si12;
            end
            10'h00a: begin
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.imm             = imm_si12;
            end
            10'h00d: begin
                dec.alu_op[ALU_AND] = 1'b1;
                dec.imm             = imm_ui12;
            end
            10'h00e: begin
                dec.alu_op[ALU_OR] = 1'b1;
                dec.imm            = imm_ui12;
            end
            10'h0a2: begin
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.imm             = imm_si12;
                dec.mem_op          = 2'b01;
            end
            10'h0a6: begin
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.imm             = imm_si12;
                dec.mem_op          = 2'b10;
                src2_is_rd          = 1'b1;
                use_src2            = 1'b1;
            end
            default: ;
        endcase
        if (op10 inside {10'h008, 10'h00a, 10'h00d, 10'h00e, 10'h0a2, 10'h0a6}) begin
            dec.inst_valid = 1'b1;
            dec.we         = (op10 != 10'h0a6);
            dec.sel_src2   = 1'b1;
            use_rj         = 1'b1;
        end

        case (op7)
            7'h0a: begin
                dec.inst_valid      = 1'b1;
                dec.we              = 1'b1;
                dec.alu_op[ALU_LUI] = 1'b1;
                dec.imm             = imm_si20;
                dec.sel_src2        = 1'b1;
            end
            7'h0e: begin
                dec.inst_valid      = 1'b1;
                dec.we              = 1'b1;
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.imm             = imm_si20;
                dec.sel_src1        = 1'b1;
                dec.sel_src2        = 1'b1;
            end
            default: ;
        endcase

        // Link-writing branches compute pc-relative results in EXE, hence add with pc as src1.
        case (op6)
            6'h13: begin
                dec.inst_valid       = 1'b1;
                dec.we               = 1'b1;
                dec.br_op[BR_JIRL]   = 1'b1;
                dec.alu_op[ALU_ADD]  = 1'b1;
                dec.sel_src1         = 1'b1;
                dec.imm              = imm_offs16;
                use_rj               = 1'b1;
            end
            6'h14: begin
                dec.inst_valid = 1'b1;
                dec.br_op[BR_B] = 1'b1;
                dec.imm        = imm_offs26;
            end
            6'h15: begin
                dec.inst_valid      = 1'b1;
                dec.we              = 1'b1;
                dec.br_op[BR_BL]    = 1'b1;
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.sel_src1        = 1'b1;
                dec.imm             = imm_offs26;
                dec.rd              = 5'd1;
            end
            6'h16, 6'h17: begin
                dec.inst_valid = 1'b1;
                dec.br_op[(op6 == 6'h16) ? BR_BEQ : BR_BNE] = 1'b1;
                dec.imm        = imm_offs16;
                src2_is_rd     = 1'b1;
                use_rj         = 1'b1;
                use_src2       = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_index1 = in_inst[9:5];
    assign reg_index2 = src2_is_rd ? in_inst[4:0] : in_inst[14:10];

    logic hazard;
    assign hazard = ex_ld_valid && (ex_ld_rd != 5'd0) &&
                    ((use_rj && (reg_index1 == ex_ld_rd)) ||
                     (use_src2 && (reg_index2 == ex_ld_rd)));

    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   in_fire;
    logic   out_fire;

    // With the skid entry, in_ready is a flop output and ignores out_ready and hazard.
    assign in_ready = SKID_EN ? ~skid_valid : ((~main_valid | out_ready) & ~hazard);
    assign in_fire  = in_valid & in_ready & ~hazard & ~flush;
    assign out_fire = main_valid & out_ready;

    // Main/skid occupancy: skid refills main first to keep order; flush only drops valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) main_q <= dec;
            end
        end else if (in_fire && SKID_EN) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid      = main_valid;
    assign out_pc         = main_q.pc;
    assign out_inst       = main_q.inst;
    assign out_src1       = main_q.src1;
    assign out_src2       = main_q.src2;
    assign out_imm        = main_q.imm;
    assign out_rd         = main_q.rd;
    assign out_we         = main_q.we;
    assign out_alu_op     = main_q.alu_op;
    assign out_br_op      = main_q.br_op;
    assign out_mem_op     = main_q.mem_op;
    assign out_sel_src1   = main_q.sel_src1;
    assign out_sel_src2   = main_q.sel_src2;
    assign out_inst_valid = main_q.inst_valid;

endmodule

// File: tb/tb_id_stage_v2.sv
// Testbench for id_stage_v2 (SKID_EN=1): table-driven decode model plus an
// entry queue standing in for the stage's buffering.
module tb_id_stage_v2;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  reg_index1, reg_index2;
    logic [31:0] reg_data1, reg_data2;
    logic        ex_ld_valid;
    logic [4:0]  ex_ld_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst, out_src1, out_src2, out_imm;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [13:0] out_alu_op;
    logic [7:0]  out_br_op;
    logic [1:0]  out_mem_op;
    logic        out_sel_src1, out_sel_src2, out_inst_valid;

    logic [31:0] rf [32];
    assign reg_data1 = rf[reg_index1];
    assign reg_data2 = rf[reg_index2];

    always #5 clk = ~clk;

    id_stage_v2 #(.ALU_OP_W(14), .BR_OP_W(8), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .reg_index1(reg_index1), .reg_index2(reg_index2),
        .reg_data1(reg_data1), .reg_data2(reg_data2),
        .ex_ld_valid(ex_ld_valid), .ex_ld_rd(ex_ld_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_src1(out_src1), .out_src2(out_src2),
        .out_imm(out_imm), .out_rd(out_rd), .out_we(out_we), .out_alu_op(out_alu_op),
        .out_br_op(out_br_op), .out_mem_op(out_mem_op), .out_sel_src1(out_sel_src1),
        .out_sel_src2(out_sel_src2), .out_inst_valid(out_inst_valid)
    );

    int tests = 0;
    int fails = 0;

    // immk: 0 none, 1 si12, 2 ui12, 3 si20, 4 offs16, 5 offs26
    typedef struct {
        logic [31:0] opc;
        int          w;
        int          immk;
        int          alu;
        int          br;
        logic [1:0]  mem;
        bit          we, urj, us2, s2rd, sel1, sel2;
    } row_t;
    row_t rows[$];

    typedef struct {
        logic [31:0] pc, inst, src1, src2, imm;
        logic [4:0]  rd, idx2;
        logic        we, s1, s2, iv;
        logic [13:0] alu;
        logic [7:0]  br;
        logic [1:0]  mem;
        bit          defd, isbr, use_rj, use_s2;
    } exp_t;
    exp_t q[$];

    task automatic add_row(input logic [31:0] opc, input int w, input int immk, input int alu,
                           input int br, input logic [1:0] mem, input bit we, input bit urj,
                           input bit us2, input bit s2rd, input bit sel1, input bit sel2);
        row_t r;
        r.opc = opc; r.w = w; r.immk = immk; r.alu = alu; r.br = br; r.mem = mem;
        r.we = we; r.urj = urj; r.us2 = us2; r.s2rd = s2rd; r.sel1 = sel1; r.sel2 = sel2;
        rows.push_back(r);
    endtask

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   v;
        e.pc = pc; e.inst = inst; e.src1 = '0; e.src2 = '0; e.imm = '0;
        e.rd = inst[4:0]; e.idx2 = inst[14:10];
        e.we = 1'b0; e.s1 = 1'b0; e.s2 = 1'b0; e.iv = 1'b0;
        e.alu = '0; e.br = '0; e.mem = 2'b00;
        e.defd = 1'b0; e.isbr = 1'b0; e.use_rj = 1'b0; e.use_s2 = 1'b0;
        foreach (rows[i]) begin
            if ((inst >> (32 - rows[i].w)) == rows[i].opc) begin
                e.defd = 1'b1; e.iv = 1'b1;
                e.we = rows[i].we; e.s1 = rows[i].sel1; e.s2 = rows[i].sel2;
                e.mem = rows[i].mem; e.use_rj = rows[i].urj; e.use_s2 = rows[i].us2;
                e.isbr = (rows[i].br >= 0);
                if (rows[i].alu >= 0) e.alu = 14'd1 << rows[i].alu;
                if (rows[i].br >= 0) e.br = 8'd1 << rows[i].br;
                if (rows[i].s2rd) e.idx2 = inst[4:0];
                if (rows[i].br == 2) e.rd = 5'd1;
                case (rows[i].immk)
                    1: begin v = int'(inst[21:10]); if (v >= 2048) v -= 4096; e.imm = 32'(v); end
                    2: e.imm = 32'(int'(inst[21:10]));
                    3: e.imm = {12'h0, inst[24:5]} * 32'd4096;
                    4: begin v = int'(inst[25:10]); if (v >= 32768) v -= 65536; e.imm = 32'(v * 4); end
                    5: begin
                        v = int'({inst[9:0], inst[25:10]});
                        if (v >= 33554432) v -= 67108864;
                        e.imm = 32'(v * 4);
                    end
                    default: e.imm = '0;
                endcase
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        exp_t e;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            chk("out_pc", out_pc, e.pc);
            chk("out_inst", out_inst, e.inst);
            chk("out_imm", out_imm, e.imm);
            chk("out_we", 32'(out_we), 32'(e.we));
            chk("out_mem_op", 32'(out_mem_op), 32'(e.mem));
            chk("out_br_op", 32'(out_br_op), 32'(e.br));
            chk("out_inst_valid", 32'(out_inst_valid), 32'(e.iv));
            chk("out_src1", out_src1, e.src1);
            if (e.defd) begin
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_src2", out_src2, e.src2);
            end
            if (e.defd && !e.isbr) begin
                chk("out_alu_op", 32'(out_alu_op), 32'(e.alu));
                chk("out_sel_src1", 32'(out_sel_src1), 32'(e.s1));
                chk("out_sel_src2", 32'(out_sel_src2), 32'(e.s2));
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst, input logic ordy,
                         input logic ldv, input logic [4:0] ldrd, input logic fl, output bit fired);
        exp_t        e;
        bit          hz;
        logic [31:0] pc;
        @(negedge clk);
        check_model();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        pc = $urandom & 32'hffff_fffc;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        ex_ld_valid = ldv; ex_ld_rd = ldrd; flush = fl;
        e = model(inst, pc);
        #1;
        if (iv) begin
            chk("reg_index1", 32'(reg_index1), 32'(inst[9:5]));
            if (e.defd && e.use_s2) chk("reg_index2", 32'(reg_index2), 32'(e.idx2));
        end
        hz = ldv && (ldrd != 5'd0) &&
             ((e.use_rj && (inst[9:5] == ldrd)) || (e.use_s2 && (e.idx2 == ldrd)));
        fired = iv && (q.size() < 2) && !hz && !fl;
        e.src1 = rf[inst[9:5]];
        e.src2 = rf[e.idx2];
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && ordy) q.delete(0);
            if (fired) q.push_back(e);
        end
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic ordy, input int maxc);
        bit f;
        int n;
        f = 1'b0; n = 0;
        while (!f && n < maxc) begin
            drive(1'b1, inst, ordy, 1'b0, 5'd0, 1'b0, f);
            n++;
        end
        chk("accept_within_budget", 32'(f), 32'd1);
    endtask

    task automatic idle(input int n);
        bit f;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, f);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit          f;
        logic [31:0] inst, m, o;
        int          r;

        add_row(32'h00020, 17, 0, 0, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h00022, 17, 0, 1, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h00024, 17, 0, 2, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h00025, 17, 0, 3, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h00029, 17, 0, 4, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h0002a, 17, 0, 5, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h0002b, 17, 0, 6, -1, 2'b00, 1, 1, 1, 0, 0, 0);
        add_row(32'h008, 10, 1, 2, -1, 2'b00, 1, 1, 0, 0, 0, 1);
        add_row(32'h00a, 10, 1, 0, -1, 2'b00, 1, 1, 0, 0, 0, 1);
        add_row(32'h00d, 10, 2, 4, -1, 2'b00, 1, 1, 0, 0, 0, 1);
        add_row(32'h00e, 10, 2, 5, -1, 2'b00, 1, 1, 0, 0, 0, 1);
        add_row(32'h0a2, 10, 1, 0, -1, 2'b01, 1, 1, 0, 0, 0, 1);
        add_row(32'h0a6, 10, 1, 0, -1, 2'b10, 0, 1, 1, 1, 0, 1);
        add_row(32'h0a, 7, 3, 7, -1, 2'b00, 1, 0, 0, 0, 0, 1);
        add_row(32'h0e, 7, 3, 0, -1, 2'b00, 1, 0, 0, 0, 1, 1);
        add_row(32'h13, 6, 4, -1, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        add_row(32'h14, 6, 5, -1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        add_row(32'h15, 6, 5, -1, 2, 2'b00, 1, 0, 0, 0, 0, 0);
        add_row(32'h16, 6, 4, -1, 3, 2'b00, 0, 1, 1, 1, 0, 0);
        add_row(32'h17, 6, 4, -1, 4, 2'b00, 0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; ex_ld_valid = 1'b0; ex_ld_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_src1", out_src1, 32'd0);
        chk("rst_out_src2", out_src2, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_ctrl", {8'h0, out_rd, out_we, out_alu_op, out_mem_op, out_sel_src1,
                         out_sel_src2, out_inst_valid}, 32'd0);
        chk("rst_out_br_op", 32'(out_br_op), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // or r1,r2,r3 / addi.w -1 / bl -1
        drive(1'b1, 32'h00150c41, 1'b1, 1'b0, 5'd0, 1'b0, f);
        chk("or_valid", 32'(out_valid), 32'd1);
        chk("or_alu_op", 32'(out_alu_op), 32'h20);
        chk("or_rd", 32'(out_rd), 32'd1);
        chk("or_we", 32'(out_we), 32'd1);
        chk("or_index1", 32'(reg_index1), 32'd2);
        chk("or_index2", 32'(reg_index2), 32'd3);
        drive(1'b1, 32'h02bffc41, 1'b1, 1'b0, 5'd0, 1'b0, f);
        chk("addi_imm", out_imm, 32'hffffffff);
        chk("addi_sel_src2", 32'(out_sel_src2), 32'd1);
        drive(1'b1, 32'h57ffffff, 1'b1, 1'b0, 5'd0, 1'b0, f);
        chk("bl_imm", out_imm, 32'hfffffffc);
        chk("bl_rd", 32'(out_rd), 32'd1);
        chk("bl_br_op", 32'(out_br_op), 32'h04);
        idle(2);

        // skid: A, B held with out_ready low, C waits, then all drain in order
        present(32'h02800421, 1'b0, 1);
        present(32'h02800842, 1'b0, 1);
        chk("skid_in_ready_full", 32'(in_ready), 32'd0);
        chk("skid_head_a", out_inst, 32'h02800421);
        present(32'h02800c63, 1'b1, 4);
        chk("skid_head_c", out_inst, 32'h02800c63);
        idle(2);

        // load-use: add.w r6,r5,r7 against a load to r5
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00101ca6, 1'b1, 1'b1, 5'd5, 1'b0, f);
            chk("hazard_blocked", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 32'h00101ca6, 1'b1, 1'b0, 5'd5, 1'b0, f);
        chk("hazard_release_valid", 32'(out_valid), 32'd1);
        chk("hazard_release_inst", out_inst, 32'h00101ca6);
        idle(1);

        // flush with both entries full and a new instruction presented
        present(32'h02800421, 1'b0, 1);
        present(32'h02800842, 1'b0, 1);
        drive(1'b1, 32'h02801084, 1'b0, 1'b0, 5'd0, 1'b1, f);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // undefined instruction is still forwarded
        drive(1'b1, 32'hffffffff, 1'b1, 1'b0, 5'd0, 1'b0, f);
        chk("undef_valid", 32'(out_valid), 32'd1);
        chk("undef_inst_valid", 32'(out_inst_valid), 32'd0);
        chk("undef_we", 32'(out_we), 32'd0);
        chk("undef_imm", out_imm, 32'd0);
        idle(1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, rows.size()));
            if (r == rows.size()) begin
                inst = $urandom;
                inst[31:26] = 6'h3f;
            end else begin
                m = 32'hffffffff >> rows[r].w;
                o = rows[r].opc << (32 - rows[r].w);
                inst = ($urandom & m) | o;
                inst[4:0]   = 5'($urandom_range(0, 7));
                inst[9:5]   = 5'($urandom_range(0, 7));
                inst[14:10] = 5'($urandom_range(0, 7));
            end
            drive(1'($urandom_range(0, 9) < 7), inst, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 31) == 0), f);
        end
        idle(4);
        @(negedge clk);
        check_model();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_stage_v2.md
Name: id_stage_v2

Overview:
- Second-generation decode stage: sits between the fetch stage and EXE.
- Decodes an extended LA32R integer subset, covering ALU register, ALU immediate, upper-immediate, branch and load/store instructions.
- Reads the regfile combinationally and registers a structured control word.
- Adds three things the first generation lacked:
  - correct valid/ready pipeline semantics;
  - an optional skid register, so in_ready is registered and never depends on out_ready;
  - load-use interlock against the EXE stage.

Parameters:
ALU_OP_W, 14, width of one-hot ALU opcode
BR_OP_W, 8, width of one-hot branch opcode
SKID_EN, 1, 1 = two-entry (main+skid) buffering with registered in_ready; 0 = single register, in_ready = ~out_valid | out_ready

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held and incoming instructions
in_valid  in  1  fetch data valid
in_ready  out  1  stage can accept
in_pc  in  32  instruction address
in_inst  in  32  instruction word
reg_index1  out  5  regfile read port 1 index (rj)
reg_index2  out  5  regfile read port 2 index (rk, or rd for st.w/beq/bne)
reg_data1  in  32  read data 1
reg_data2  in  32  read data 2
ex_ld_valid  in  1  EXE holds a valid load
ex_ld_rd  in  5  destination of that load
out_valid  out  1  output entry valid
out_ready  in  1  EXE accepts
out_pc  out  32  pc
out_inst  out  32  instruction word
out_src1  out  32  reg_data1 captured
out_src2  out  32  reg_data2 captured
out_imm  out  32  extended immediate
out_rd  out  5  write index (1 for bl)
out_we  out  1  regfile write enable
out_alu_op  out  ALU_OP_W  one-hot: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 lui (src2 pass)
out_br_op  out  BR_OP_W  one-hot: 0 jirl, 1 b, 2 bl, 3 beq, 4 bne
out_mem_op  out  2  01 ld.w, 10 st.w, 00 none
out_sel_src1  out  1  1 = pc replaces src1
out_sel_src2  out  1  1 = imm replaces src2
out_inst_valid  out  1  0 = undefined instruction (still forwarded, for exception/difftest)

Behaviour:
- Reset: out_valid=0, skid empty, in_ready=1; every data output = 0.
- Decode by in_inst[31:15] / [31:22] / [31:25] / [31:26]:
  - ALU register instructions (bits [31:15]): add.w 0x00020, sub.w 0x00022, slt 0x00024, sltu 0x00025, and 0x00029, or 0x0002a, xor 0x0002b.
  - ALU immediate and load/store (bits [31:22]): slti 0x008, addi.w 0x00a, andi 0x00d, ori 0x00e, ld.w 0x0a2, st.w 0x0a6.
  - Upper-immediate (bits [31:25]): lu12i.w 0x0a, pcaddu12i 0x0e.
  - Branches (bits [31:26]): jirl 0x13, b 0x14, bl 0x15, beq 0x16, bne 0x17.
- Immediates:
  - si12 sign-extended: addi, slti, ld, st.
  - ui12 zero-extended: andi, ori.
  - {si20,12'h0}: lu12i, pcaddu12i.
  - sext(offs16)<<2: jirl, beq, bne.
  - sext({inst[9:0],inst[25:10]})<<2: b, bl.
  - Undefined instructions: imm=0.
- Write enable:
  - out_we=0 for st, beq, bne, b, and undefined instructions.
  - Writes with rd=0 still assert out_we; EXE/WB ignore r0.
- Load-use:
  - hazard = ex_ld_valid & ex_ld_rd!=0 & (rj match when rj used, or src2 index match when src2 used).
  - On hazard, the instruction is not accepted: in_ready forced 0 that cycle when SKID_EN=0; when SKID_EN=1, the accept qualifier is masked and in_ready stays as registered.
- Accept: in_fire = in_valid & in_ready & ~hazard & ~flush. Regfile data is captured on in_fire, giving one-cycle latency to out_valid.
- SKID_EN=1 behaviour:
  - in_ready = ~skid_valid, registered.
  - If in_fire occurs while out_valid & ~out_ready, the entry goes to skid.
  - On output fire, skid moves to main the same cycle, or main is reloaded by a simultaneous in_fire.
  - Order is preserved; no entry is ever dropped or duplicated.
- Flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - The input presented in the flush cycle is discarded.
  - Flush has priority over in_fire and out_ready.
- out_* fields are stable while out_valid & ~out_ready.

Test Plan:
- Reset then in_valid=1, inst=0x00150c41 (or r1,r2,r3), out_ready=1 -> next cycle out_valid=1, out_alu_op bit5, out_rd=1, out_we=1, reg_index1=2, reg_index2=3.
- addi.w imm -1 (0x02bffc41) -> out_imm=0xffffffff, sel_src2=1. Then bl offs26=-1 (0x57ffffff) -> out_imm=0xfffffffc, out_rd=1, br_op bit2.
- SKID_EN=1: out_ready=0, feed 3 back-to-back instructions -> 2 held, in_ready=0 from cycle 2. Raise out_ready -> outputs emerge in order A,B,C with no loss.
- ex_ld_valid=1, ex_ld_rd=5; feed add.w rd=6, rj=5 -> not accepted while the hazard holds; accepted the cycle after ex_ld_valid drops.
- Flush while both entries are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the discarded instruction never appears.
- Undefined inst 0xffffffff -> out_valid=1, out_inst_valid=0, out_we=0, out_imm=0.
